tone_synth: RTL and testbench

//  Downstream of the song sequencer. Converts four 4-bit tone codes and the 8-bit note index into audio.

---
 rtl/tone_synth_if.sv | 22 ++
 rtl/tone_synth.sv | 155 +++++++++++++++
 tb/tb_tone_synth.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tone_synth_if.sv
// Sequencer-to-synth bus: per-voice tone codes and beat index in,
// mixed sample, PWM audio and voice status out.
interface tone_synth_if;
  logic [3:0] tone0;
  logic [3:0] tone1;
  logic [3:0] tone2;
  logic [3:0] tone3;
  logic [7:0] note_index;
  logic [5:0] sample;
  logic       pwm_out;
  logic [3:0] voice_active;

  modport master (
    output tone0, tone1, tone2, tone3, note_index,
    input  sample, pwm_out, voice_active
  );

  modport slave (
    input  tone0, tone1, tone2, tone3, note_index,
    output sample, pwm_out, voice_active
  );
endinterface

// File: rtl/tone_synth.sv
// Four square-wave voices sharing one decay envelope, mixed into a 6-bit
// sample that drives a 63-cycle PWM audio output.
module tone_synth #(
  parameter int DIV_W       = 16,
  parameter int BASE_HALF   = 47778,
  parameter int STEP        = 2000,
  parameter int DECAY_TICKS = 250000
) (
  input  logic        clk,
  input  logic        reset_n,
  tone_synth_if.slave bus
);

  localparam int              DEC_W    = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_TICKS - 1);
  localparam logic [5:0]      PWM_LAST = 6'd62;

  // Counter reload value for a tone code: half-period minus one.
  function automatic logic [DIV_W-1:0] reload_of(input logic [3:0] code);
    int half;
    half = BASE_HALF - (int'(code) - 1) * STEP;
    return DIV_W'(half - 1);
  endfunction

  logic [3:0] tone_in [4];
  assign tone_in[0] = bus.tone0;
  assign tone_in[1] = bus.tone1;
  assign tone_in[2] = bus.tone2;
  assign tone_in[3] = bus.tone3;

  logic [7:0] prev_index_q;
  logic       new_beat;
  logic       any_tone;
  logic [3:0] tone_nz;

  assign tone_nz  = {bus.tone3 != 4'd0, bus.tone2 != 4'd0,
                     bus.tone1 != 4'd0, bus.tone0 != 4'd0};
  assign any_tone = |tone_nz;
  assign new_beat = (bus.note_index != prev_index_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_index_q <= '0;
    else          prev_index_q <= bus.note_index;
  end

  logic [3:0] sq;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_voice
      logic [3:0]       tone_reg_q, tone_reg_d;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic             sq_q, sq_d;

      // A beat restarts the phase so all voices of a chord start aligned.
      always_comb begin
        tone_reg_d = tone_reg_q;
        cnt_d      = cnt_q;
        sq_d       = sq_q;
        if (new_beat) begin
          tone_reg_d = tone_in[gi];
          cnt_d      = (tone_in[gi] == 4'd0) ? '0 : reload_of(tone_in[gi]);
          sq_d       = 1'b0;
        end else if (tone_reg_q == 4'd0) begin
          cnt_d = '0;
          sq_d  = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d = reload_of(tone_reg_q);
          sq_d  = ~sq_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          tone_reg_q <= '0;
          cnt_q      <= '0;
          sq_q       <= 1'b0;
        end else begin
          tone_reg_q <= tone_reg_d;
          cnt_q      <= cnt_d;
          sq_q       <= sq_d;
        end
      end

      assign sq[gi] = sq_q;
    end
  endgenerate

  logic [3:0]       amp_q, amp_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;

  // Beat wins over a coinciding decay wrap; amplitude floors at zero.
  always_comb begin
    amp_d     = amp_q;
    dec_cnt_d = dec_cnt_q;
    if (new_beat) begin
      amp_d     = any_tone ? 4'd15 : 4'd0;
      dec_cnt_d = '0;
    end else if (dec_cnt_q == DEC_LAST) begin
      dec_cnt_d = '0;
      if (amp_q != 4'd0) amp_d = amp_q - 4'd1;
    end else begin
      dec_cnt_d = dec_cnt_q + DEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amp_q     <= '0;
      dec_cnt_q <= '0;
    end else begin
      amp_q     <= amp_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end

  logic [5:0] sample_q, sample_d;
  logic [5:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_q, pwm_d;
  logic [3:0] voice_active_q, voice_active_d;

  always_comb begin
    sample_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sq[i]) sample_d = sample_d + {2'b00, amp_q};
    end
  end

  always_comb begin
    pwm_cnt_d      = (pwm_cnt_q == PWM_LAST) ? 6'd0 : pwm_cnt_q + 6'd1;
    pwm_d          = (pwm_cnt_q < sample_q);
    voice_active_d = new_beat ? tone_nz : voice_active_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q       <= '0;
      pwm_cnt_q      <= '0;
      pwm_q          <= 1'b0;
      voice_active_q <= '0;
    end else begin
      sample_q       <= sample_d;
      pwm_cnt_q      <= pwm_cnt_d;
      pwm_q          <= pwm_d;
      voice_active_q <= voice_active_d;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.pwm_out      = pwm_q;
  assign bus.voice_active = voice_active_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: three instances with small dividers/decay
// so oscillator, envelope, mix and PWM timing can be checked by hand.
module tb_tone_synth;
  logic clk;
  logic rst_a_n, rst_b_n, rst_c_n;

  tone_synth_if bus_a ();
  tone_synth_if bus_b ();
  tone_synth_if bus_c ();

  tone_synth #(.DIV_W(16), .BASE_HALF(10), .STEP(2), .DECAY_TICKS(10000)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .bus(bus_a)
  );
  tone_synth #(.DIV_W(16), .BASE_HALF(10), .STEP(2), .DECAY_TICKS(4)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .bus(bus_b)
  );
  tone_synth #(.DIV_W(16), .BASE_HALF(400), .STEP(2), .DECAY_TICKS(100000)) dut_c (
    .clk(clk), .reset_n(rst_c_n), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  int hi;
  int w;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic adv_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%0d exp=%0d", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    bus_a.tone0 = 4'd0; bus_a.tone1 = 4'd0; bus_a.tone2 = 4'd0; bus_a.tone3 = 4'd0;
    bus_b.tone0 = 4'd0; bus_b.tone1 = 4'd0; bus_b.tone2 = 4'd0; bus_b.tone3 = 4'd0;
    bus_c.tone0 = 4'd0; bus_c.tone1 = 4'd0; bus_c.tone2 = 4'd0; bus_c.tone3 = 4'd0;
    bus_a.note_index = 8'd0; bus_b.note_index = 8'd0; bus_c.note_index = 8'd0;

    // Held in reset: all outputs quiet.
    repeat (3) step();
    check("rst_a_sample", bus_a.sample, 8'd0);
    check("rst_a_pwm", bus_a.pwm_out, 8'd0);
    check("rst_a_va", bus_a.voice_active, 8'd0);
    check("rst_b_sample", bus_b.sample, 8'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;

    // Tone present but index still equals prev (0): no beat.
    bus_a.tone0 = 4'd1;
    repeat (15) step();
    check("nobeat_va", bus_a.voice_active, 8'd0);
    check("nobeat_sample", bus_a.sample, 8'd0);

    // Single voice, half=10: sample alternates 15/0.
    bus_a.note_index = 8'd1;
    step(); cyc = 0;
    check("t2_va", bus_a.voice_active, 8'b0001);
    adv_to(10); check("t2_s10", bus_a.sample, 8'd0);
    adv_to(11); check("t2_s11", bus_a.sample, 8'd15);
    adv_to(20); check("t2_s20", bus_a.sample, 8'd15);
    adv_to(21); check("t2_s21", bus_a.sample, 8'd0);
    adv_to(31); check("t2_s31", bus_a.sample, 8'd15);

    // All-rest beat while the voice is high.
    adv_to(32);
    bus_a.tone0 = 4'd0; bus_a.note_index = 8'd2;
    step();
    check("t4_va", bus_a.voice_active, 8'd0);
    check("t4_s33", bus_a.sample, 8'd15);
    adv_to(34); check("t4_s34", bus_a.sample, 8'd0);
    adv_to(50); check("t4_hold", bus_a.sample, 8'd0);
    hi = 0;
    repeat (63) begin step(); if (bus_a.pwm_out === 1'b1) hi++; end
    check("t4_pwm_lo", 8'(hi), 8'd0);

    // Two voices half=6, decay every 4 cycles.
    bus_b.tone0 = 4'd3; bus_b.tone1 = 4'd3; bus_b.note_index = 8'd1;
    step(); cyc = 0;
    check("t3_va", bus_b.voice_active, 8'b0011);
    adv_to(6);   check("t3_s6", bus_b.sample, 8'd0);
    adv_to(7);   check("t3_s7", bus_b.sample, 8'd28);
    adv_to(10);  check("t3_s10", bus_b.sample, 8'd26);
    adv_to(12);  check("t3_s12", bus_b.sample, 8'd26);
    adv_to(13);  check("t3_s13", bus_b.sample, 8'd0);
    adv_to(19);  check("t3_s19", bus_b.sample, 8'd22);
    adv_to(24);  check("t3_s24", bus_b.sample, 8'd20);
    adv_to(56);  check("t3_s56", bus_b.sample, 8'd4);
    adv_to(60);  check("t3_s60", bus_b.sample, 8'd2);
    adv_to(70);  check("t3_s70", bus_b.sample, 8'd0);
    adv_to(104); check("t3_s104", bus_b.sample, 8'd0);

    // Beat landing on a decay wrap edge (and on a toggle edge).
    bus_b.tone0 = 4'd2; bus_b.tone1 = 4'd0; bus_b.note_index = 8'd2;
    step(); cyc = 0;
    check("t5_va", bus_b.voice_active, 8'b0001);
    adv_to(7);
    bus_b.note_index = 8'd3;
    step();
    check("t5_s8", bus_b.sample, 8'd0);
    adv_to(9);  check("t5_s9", bus_b.sample, 8'd0);
    adv_to(16); check("t5_s16", bus_b.sample, 8'd0);
    adv_to(17); check("t5_s17", bus_b.sample, 8'd13);

    // Full-scale sample: PWM duty 60/63, then retrigger via 255 and 255->0.
    bus_c.tone0 = 4'd1; bus_c.tone1 = 4'd1; bus_c.tone2 = 4'd1; bus_c.tone3 = 4'd1;
    bus_c.note_index = 8'd1;
    step(); cyc = 0;
    check("t6_va", bus_c.voice_active, 8'b1111);
    adv_to(400); check("t6_s400", bus_c.sample, 8'd0);
    adv_to(401); check("t6_s401", bus_c.sample, 8'd60);
    adv_to(409);
    hi = 0;
    repeat (63) begin step(); if (bus_c.pwm_out === 1'b1) hi++; end
    check("t6_pwm_hi", 8'(hi), 8'd60);
    hi = 0;
    repeat (63) begin step(); if (bus_c.pwm_out === 1'b1) hi++; end
    check("t6_pwm_hi2", 8'(hi), 8'd60);

    adv_to(600);
    bus_c.note_index = 8'd255;
    step(); cyc = 0;
    check("t6_b255_s0", bus_c.sample, 8'd60);
    adv_to(1);   check("t6_b255_s1", bus_c.sample, 8'd0);
    adv_to(401); check("t6_b255_s401", bus_c.sample, 8'd60);
    adv_to(450);
    bus_c.note_index = 8'd0;
    step(); cyc = 0;
    adv_to(1);   check("t6_wrap_s1", bus_c.sample, 8'd0);
    check("t6_wrap_va", bus_c.voice_active, 8'b1111);
    adv_to(401); check("t6_wrap_s401", bus_c.sample, 8'd60);

    // Asynchronous reset while PWM output is high.
    w = 0;
    while (bus_c.pwm_out !== 1'b1 && w < 10) begin step(); w++; end
    check("t1_pwm_pre", bus_c.pwm_out, 8'd1);
    #2 rst_c_n = 1'b0;
    #1;
    check("t1_pwm_async", bus_c.pwm_out, 8'd0);
    check("t1_s_async", bus_c.sample, 8'd0);
    check("t1_va_async", bus_c.voice_active, 8'd0);
    repeat (5) step();
    check("t1_pwm_hold", bus_c.pwm_out, 8'd0);
    check("t1_s_hold", bus_c.sample, 8'd0);
    check("t1_va_hold", bus_c.voice_active, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
